// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: inst field positions,
// the idle instruction word and the sequencer state type.
package core_inst_pkg;

    localparam int unsigned AW = 11;

    localparam int unsigned BitDebug   = 63;
    localparam int unsigned BitL1Wr    = 37;
    localparam int unsigned BitOs      = 36;
    localparam int unsigned BitRenP    = 35;
    localparam int unsigned BitPass    = 34;
    localparam int unsigned BitAcc     = 33;
    localparam int unsigned BitCenP    = 32;
    localparam int unsigned BitWenP    = 31;
    localparam int unsigned BitApLsb   = 20;
    localparam int unsigned BitCenX    = 19;
    localparam int unsigned BitWenX    = 18;
    localparam int unsigned BitAxLsb   = 7;
    localparam int unsigned BitOfifoRd = 6;
    localparam int unsigned BitIfifoWr = 5;
    localparam int unsigned BitIfifoRd = 4;
    localparam int unsigned BitL0Rd    = 3;
    localparam int unsigned BitL0Wr    = 2;
    localparam int unsigned BitExec    = 1;
    localparam int unsigned BitLoad    = 0;

    // Both memories deselected with write-enables inactive, everything else quiet.
    localparam logic [63:0] IDLE_INST = 64'h0000_0001_800C_0000;

    typedef enum logic [3:0] {
        StIdle,
        StWFetch,
        StWLoad,
        StAFetch,
        StExec,
        StDrain,
        StAccWait,
        StAccRd,
        StAccWr,
        StDone
    } state_e;

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: places named core control signals into the 64-bit inst word.
module inst_pack
    import core_inst_pkg::*;
(
    input  logic          ren_p,
    input  logic          passthrough,
    input  logic          acc,
    input  logic          cen_p,
    input  logic          wen_p,
    input  logic [AW-1:0] a_p,
    input  logic          cen_x,
    input  logic          wen_x,
    input  logic [AW-1:0] a_x,
    input  logic          ofifo_rd,
    input  logic          l0_rd,
    input  logic          l0_wr,
    input  logic          execute,
    input  logic          load,
    output logic [63:0]   inst
);

    always_comb begin
        inst                   = '0;
        inst[BitDebug]         = 1'b0;
        inst[BitL1Wr]          = 1'b0;
        inst[BitOs]            = 1'b0;
        inst[BitRenP]          = ren_p;
        inst[BitPass]          = passthrough;
        inst[BitAcc]           = acc;
        inst[BitCenP]          = cen_p;
        inst[BitWenP]          = wen_p;
        inst[BitApLsb +: AW]   = a_p;
        inst[BitCenX]          = cen_x;
        inst[BitWenX]          = wen_x;
        inst[BitAxLsb +: AW]   = a_x;
        inst[BitOfifoRd]       = ofifo_rd;
        inst[BitIfifoWr]       = 1'b0;
        inst[BitIfifoRd]       = 1'b0;
        inst[BitL0Rd]          = l0_rd;
        inst[BitL0Wr]          = l0_wr;
        inst[BitExec]          = execute;
        inst[BitLoad]          = load;
    end

endmodule

// File: rtl/core_inst_seq.sv
// Instruction sequencer for one weight-stationary tile: weight/activation fetch,
// MAC execution and drain, then OFIFO -> PSUM read-modify-write per output vector.
module core_inst_seq
    import core_inst_pkg::*;
#(
    parameter int unsigned row = 8,
    parameter int unsigned col = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] n_act,
    input  logic [AW-1:0] w_base,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] p_base,
    input  logic          acc_en,
    input  logic          relu_en,
    input  logic          ofifo_valid,
    output logic [63:0]   inst,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] RowW     = AW'(row);
    localparam logic [AW-1:0] RowColM1 = AW'(row + col - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] phase_q, phase_d;
    logic [AW-1:0] j_q, j_d;
    logic [AW-1:0] n_act_q, w_base_q, a_base_q, p_base_q;
    logic [AW-1:0] n_act_n, w_base_n, a_base_n, p_base_n;
    logic          acc_en_q, relu_en_q, acc_en_n, relu_en_n;
    logic          load_cfg;
    logic [63:0]   inst_q, word_d;
    logic          busy_q, done_q;

    logic          ren_p, passthrough, acc, cen_p, wen_p, cen_x, wen_x;
    logic          ofifo_rd, l0_rd, l0_wr, execute, load;
    logic [AW-1:0] a_p, a_x;

    // Next state and counters.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + AW'(1);
        j_d      = j_q;
        load_cfg = 1'b0;
        case (state_q)
            StIdle: begin
                phase_d = '0;
                j_d     = '0;
                if (start) begin
                    load_cfg = 1'b1;
                    state_d  = StWFetch;
                end
            end
            StWFetch: if (phase_q == RowW) begin
                phase_d = '0;
                state_d = StWLoad;
            end
            StWLoad: if (phase_q == RowColM1) begin
                phase_d = '0;
                state_d = (n_act_q == '0) ? StDone : StAFetch;
            end
            StAFetch: if (phase_q == n_act_q) begin
                phase_d = '0;
                state_d = StExec;
            end
            StExec: if (phase_q == n_act_q - AW'(1)) begin
                phase_d = '0;
                state_d = StDrain;
            end
            StDrain: if (phase_q == RowColM1) begin
                phase_d = '0;
                j_d     = '0;
                state_d = StAccWait;
            end
            StAccWait: begin
                phase_d = '0;
                if (ofifo_valid) state_d = StAccRd;
            end
            StAccRd: begin
                phase_d = '0;
                state_d = StAccWr;
            end
            StAccWr: begin
                phase_d = '0;
                j_d     = j_q + AW'(1);
                state_d = (j_q == n_act_q - AW'(1)) ? StDone : StAccWait;
            end
            StDone: begin
                phase_d = '0;
                state_d = StIdle;
            end
            default: begin
                phase_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign n_act_n   = load_cfg ? n_act   : n_act_q;
    assign w_base_n  = load_cfg ? w_base  : w_base_q;
    assign a_base_n  = load_cfg ? a_base  : a_base_q;
    assign p_base_n  = load_cfg ? p_base  : p_base_q;
    assign acc_en_n  = load_cfg ? acc_en  : acc_en_q;
    assign relu_en_n = load_cfg ? relu_en : relu_en_q;

    // Control fields for the upcoming state, so the registered word lines up with it.
    always_comb begin
        ren_p       = 1'b0;
        passthrough = 1'b0;
        acc         = 1'b0;
        cen_p       = 1'b1;
        wen_p       = 1'b1;
        a_p         = '0;
        cen_x       = 1'b1;
        wen_x       = 1'b1;
        a_x         = '0;
        ofifo_rd    = 1'b0;
        l0_rd       = 1'b0;
        l0_wr       = 1'b0;
        execute     = 1'b0;
        load        = 1'b0;
        if (state_d != StIdle && state_d != StDone) begin
            passthrough = ~relu_en_n;
            acc         = acc_en_n;
        end
        case (state_d)
            StWFetch: begin
                if (phase_d < RowW) begin
                    cen_x = 1'b0;
                    a_x   = w_base_n + phase_d;
                end
                l0_wr = (phase_d != '0);
            end
            StWLoad: begin
                load  = 1'b1;
                l0_rd = (phase_d < RowW);
            end
            StAFetch: begin
                if (phase_d < n_act_n) begin
                    cen_x = 1'b0;
                    a_x   = a_base_n + phase_d;
                end
                l0_wr = (phase_d != '0);
            end
            StExec: begin
                l0_rd   = 1'b1;
                execute = 1'b1;
            end
            StDrain: execute = 1'b1;
            StAccRd: if (acc_en_n) begin
                cen_p = 1'b0;
                ren_p = 1'b1;
                a_p   = p_base_n + j_d;
            end
            StAccWr: begin
                cen_p    = 1'b0;
                wen_p    = 1'b0;
                a_p      = p_base_n + j_d;
                ofifo_rd = 1'b1;
            end
            default: ;
        endcase
    end

    inst_pack u_inst_pack (
        .ren_p       (ren_p),
        .passthrough (passthrough),
        .acc         (acc),
        .cen_p       (cen_p),
        .wen_p       (wen_p),
        .a_p         (a_p),
        .cen_x       (cen_x),
        .wen_x       (wen_x),
        .a_x         (a_x),
        .ofifo_rd    (ofifo_rd),
        .l0_rd       (l0_rd),
        .l0_wr       (l0_wr),
        .execute     (execute),
        .load        (load),
        .inst        (word_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            j_q       <= '0;
            n_act_q   <= '0;
            w_base_q  <= '0;
            a_base_q  <= '0;
            p_base_q  <= '0;
            acc_en_q  <= 1'b0;
            relu_en_q <= 1'b0;
            inst_q    <= IDLE_INST;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            j_q       <= j_d;
            n_act_q   <= n_act_n;
            w_base_q  <= w_base_n;
            a_base_q  <= a_base_n;
            p_base_q  <= p_base_n;
            acc_en_q  <= acc_en_n;
            relu_en_q <= relu_en_n;
            inst_q    <= word_d;
            busy_q    <= (state_d != StIdle) && (state_d != StDone);
            done_q    <= (state_d == StDone);
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
